// File: rtl/ysyx_25040101_arb_pkg.sv
// Shared types for the nebula fetch/LSU memory arbiter.
// The arbitration policy is selected with the YSYX_25040101_ARB_RR_EN macro.
package ysyx_25040101_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25040101_arb_chk.sv
// Simulation-only protocol checker for the memory arbiter: memory must not
// return a response while the request is still waiting to be accepted.
module ysyx_25040101_arb_chk
    import ysyx_25040101_arb_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input arb_state_e state,
    input logic       mem_rsp_valid
);

    rsp_in_req_a: assert property (@(posedge clk) disable iff (rst)
        !((state == REQ) && mem_rsp_valid));

endmodule

// File: rtl/ysyx_25040101_arb_pick.sv
// Combinational winner selection between the fetch and load/store requesters.
// With YSYX_25040101_ARB_RR_EN defined, a conflict goes to the requester that
// did not win last time; otherwise LSU always beats IFU and last_grant is unused.
module ysyx_25040101_arb_pick
    import ysyx_25040101_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_grant,
    output logic any_valid,
    output logic winner
);

    assign any_valid = ifu_valid | lsu_valid;

`ifdef YSYX_25040101_ARB_RR_EN
    // Round-robin: on conflict, grant the side that was not granted last.
    always_comb begin
        winner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            winner = (last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_valid) begin
            winner = OWN_LSU;
        end else begin
            winner = OWN_IFU;
        end
    end
`else
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;

    // Fixed priority: loads/stores always win over instruction fetch.
    always_comb begin
        winner = OWN_IFU;
        if (lsu_valid) begin
            winner = OWN_LSU;
        end else begin
            winner = OWN_IFU;
        end
    end
`endif

endmodule

// File: rtl/ysyx_25040101_mem_arbiter.sv
// Two-requester memory arbiter: fetch and load/store share one memory port,
// one outstanding transaction at a time (IDLE -> REQ -> RSP).
// Optional round-robin arbitration: define YSYX_25040101_ARB_RR_EN.
module ysyx_25040101_mem_arbiter
    import ysyx_25040101_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_rsp_valid_o,
    output logic [DATA_W-1:0]   ifu_rsp_data_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_rsp_valid_o,
    output logic [DATA_W-1:0]   lsu_rsp_data_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_r;
    logic                owner_r;
    logic                mem_req_valid_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_wen_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [STRB_W-1:0]   mem_wmask_r;

    logic any_valid_s;
    logic winner_s;
    logic accept_s;
    logic last_grant_s;
    logic rsp_live_s;

`ifdef YSYX_25040101_ARB_RR_EN
    logic last_grant_r;

    // Remember who won the last accept; starts at LSU so IFU wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= OWN_LSU;
        end else if (accept_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = OWN_LSU;
`endif

    ysyx_25040101_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid_i),
        .lsu_valid  (lsu_req_valid_i),
        .last_grant (last_grant_s),
        .any_valid  (any_valid_s),
        .winner     (winner_s)
    );

    // Requests are only taken in IDLE and never while reset is held.
    assign accept_s        = !rst && (state_r == IDLE) && any_valid_s;
    assign ifu_req_ready_o = accept_s && (winner_s == OWN_IFU);
    assign lsu_req_ready_o = accept_s && (winner_s == OWN_LSU);

    // Transaction FSM: latch the winner's request, present it, wait for the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            owner_r         <= OWN_IFU;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= {DATA_W{1'b0}};
            mem_wmask_r     <= {STRB_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r         <= REQ;
                        owner_r         <= winner_s;
                        mem_req_valid_r <= 1'b1;
                        if (winner_s == OWN_LSU) begin
                            mem_addr_r  <= lsu_addr_i;
                            mem_wen_r   <= lsu_wen_i;
                            mem_wdata_r <= lsu_wdata_i;
                            mem_wmask_r <= lsu_wmask_i;
                        end else begin
                            mem_addr_r  <= ifu_addr_i;
                            mem_wen_r   <= 1'b0;
                            mem_wdata_r <= {DATA_W{1'b0}};
                            mem_wmask_r <= {STRB_W{1'b0}};
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        state_r         <= RSP;
                        mem_req_valid_r <= 1'b0;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid_o = mem_req_valid_r;
    assign mem_addr_o      = mem_addr_r;
    assign mem_wen_o       = mem_wen_r;
    assign mem_wdata_o     = mem_wdata_r;
    assign mem_wmask_o     = mem_wmask_r;

    // The response goes straight through to the owner only; anything outside RSP is dropped.
    assign rsp_live_s      = !rst && (state_r == RSP) && mem_rsp_valid_i;
    assign ifu_rsp_valid_o = rsp_live_s && (owner_r == OWN_IFU);
    assign lsu_rsp_valid_o = rsp_live_s && (owner_r == OWN_LSU);
    assign ifu_rsp_data_o  = mem_rsp_data_i;
    assign lsu_rsp_data_o  = mem_rsp_data_i;

    ysyx_25040101_arb_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .state         (state_r),
        .mem_rsp_valid (mem_rsp_valid_i)
    );

endmodule

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
// Directed scoreboard bench for ysyx_25040101_mem_arbiter.
module tb_ysyx_25040101_mem_arbiter;
    import ysyx_25040101_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
    logic [31:0] ifu_addr_i, ifu_rsp_data_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_rsp_valid_o;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rsp_data_o;
    logic [3:0]  lsu_wmask_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_rsp_valid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rsp_data_i;
    logic [3:0]  mem_wmask_o;

    ysyx_25040101_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_data_o(ifu_rsp_data_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wmask_i(lsu_wmask_i), .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic        wen;
        logic [31:0] data;
    } rsp_t;

    req_t ifu_todo[$];
    req_t lsu_todo[$];
    req_t exp_req[$];
    rsp_t exp_rsp[$];
    logic grant_log[$];
    logic exp_order[6];

    int          vectors = 0;
    int          miscompares = 0;
    int          rsp_cnt = -1;
    int          stall_cnt = 0;
    int          rsp_lat = 1;
    logic [31:0] rsp_data_q = 32'h0;

    // Memory contents model: read data is a fixed function of the address.
    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'h8000_0413;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ifu_rdy"}, 32'(ifu_req_ready_o), 32'd0);
        check({tag, "_lsu_rdy"}, 32'(lsu_req_ready_o), 32'd0);
        check({tag, "_ifu_rsp"}, 32'(ifu_rsp_valid_o), 32'd0);
        check({tag, "_lsu_rsp"}, 32'(lsu_rsp_valid_o), 32'd0);
        check({tag, "_mem_vld"}, 32'(mem_req_valid_o), 32'd0);
    endtask

    // One clock: drive requesters and memory at negedge, check 1 ns later, update the model.
    task automatic cycle();
        req_t r;
        rsp_t e;
        @(negedge clk);
        if (ifu_todo.size() > 0) begin
            ifu_req_valid_i = 1'b1;
            ifu_addr_i      = ifu_todo[0].addr;
        end else begin
            ifu_req_valid_i = 1'b0;
            ifu_addr_i      = $urandom();
        end
        if (lsu_todo.size() > 0) begin
            r = lsu_todo[0];
            lsu_req_valid_i = 1'b1;
            lsu_addr_i      = r.addr;
            lsu_wen_i       = r.wen;
            lsu_wdata_i     = r.wdata;
            lsu_wmask_i     = r.wmask;
        end else begin
            lsu_req_valid_i = 1'b0;
            lsu_addr_i      = $urandom();
            lsu_wen_i       = 1'b0;
            lsu_wdata_i     = $urandom();
            lsu_wmask_i     = 4'h0;
        end
        mem_req_ready_i = mem_req_valid_o && (stall_cnt == 0);
        if (rsp_cnt == 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = rsp_data_q;
        end else begin
            mem_rsp_valid_i = 1'b0;
            mem_rsp_data_i  = $urandom();
        end
        #1;
        check("rdy_both", 32'(ifu_req_ready_o & lsu_req_ready_o), 32'd0);
        if (mem_req_valid_o) begin
            check("rdy_in_req", 32'(ifu_req_ready_o | lsu_req_ready_o), 32'd0);
            if (exp_req.size() == 0) begin
                check("mem_req_spurious", 32'(mem_req_valid_o), 32'd0);
            end else begin
                r = exp_req[0];
                check("mem_addr", mem_addr_o, r.addr);
                check("mem_wen", 32'(mem_wen_o), 32'(r.wen));
                check("mem_wmask", 32'(mem_wmask_o), 32'(r.wmask));
                if (r.wen) check("mem_wdata", mem_wdata_o, r.wdata);
            end
        end
        if (ifu_rsp_valid_o || lsu_rsp_valid_o) begin
            check("rsp_both", 32'(ifu_rsp_valid_o & lsu_rsp_valid_o), 32'd0);
            if (exp_rsp.size() == 0) begin
                check("rsp_spurious", 32'(ifu_rsp_valid_o | lsu_rsp_valid_o), 32'd0);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_owner", 32'(lsu_rsp_valid_o), 32'(e.owner));
                if (!e.wen) check("rsp_data", lsu_rsp_valid_o ? lsu_rsp_data_o : ifu_rsp_data_o, e.data);
            end
        end
        if (lsu_req_ready_o) begin
            check("lsu_rdy_no_valid", 32'(lsu_req_valid_i), 32'd1);
            if (lsu_todo.size() > 0) begin
                r = lsu_todo.pop_front();
                exp_req.push_back(r);
                exp_rsp.push_back('{OWN_LSU, r.wen, mem_data(r.addr)});
                grant_log.push_back(OWN_LSU);
            end
        end
        if (ifu_req_ready_o) begin
            check("ifu_rdy_no_valid", 32'(ifu_req_valid_i), 32'd1);
            if (ifu_todo.size() > 0) begin
                r = ifu_todo.pop_front();
                r.wen   = 1'b0;
                r.wdata = 32'h0;
                r.wmask = 4'h0;
                exp_req.push_back(r);
                exp_rsp.push_back('{OWN_IFU, 1'b0, mem_data(r.addr)});
                grant_log.push_back(OWN_IFU);
            end
        end
        if (rsp_cnt == 0) rsp_cnt = -1;
        else if (rsp_cnt > 0) rsp_cnt--;
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (exp_req.size() > 0) void'(exp_req.pop_front());
            rsp_data_q = mem_data(mem_addr_o);
            rsp_cnt    = rsp_lat;
        end else if (mem_req_valid_o && stall_cnt > 0) begin
            stall_cnt--;
        end
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n = 0;
        while ((ifu_todo.size() > 0 || lsu_todo.size() > 0 || exp_rsp.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid_i = 1'b0; ifu_addr_i = 32'h0;
        lsu_req_valid_i = 1'b0; lsu_addr_i = 32'h0; lsu_wen_i = 1'b0;
        lsu_wdata_i = 32'h0; lsu_wmask_i = 4'h0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 32'h0;

        // Reset held two cycles, then idle with no requests.
        for (int i = 0; i < 2; i++) begin
            cycle();
            check_quiet("rst");
            check("rst_addr", mem_addr_o, 32'h0);
            check("rst_wdata", mem_wdata_o, 32'h0);
            check("rst_wen", 32'(mem_wen_o), 32'd0);
            check("rst_wmask", 32'(mem_wmask_o), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_quiet("idle");
        end

        // IFU read with exact cycle timing.
        ifu_todo.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        cycle();
        check("ifu_rd_c0_rdy", 32'(ifu_req_ready_o), 32'd1);
        cycle();
        check("ifu_rd_c1_mvld", 32'(mem_req_valid_o), 32'd1);
        check("ifu_rd_c1_addr", mem_addr_o, 32'h8000_0000);
        check("ifu_rd_c1_wen", 32'(mem_wen_o), 32'd0);
        cycle();
        check("ifu_rd_c2_rsp", 32'(ifu_rsp_valid_o), 32'd0);
        cycle();
        check("ifu_rd_c3_rsp", 32'(ifu_rsp_valid_o), 32'd1);
        check("ifu_rd_c3_data", ifu_rsp_data_o, 32'h0000_0413);
        check("ifu_rd_c3_lsu", 32'(lsu_rsp_valid_o), 32'd0);
        cycle();
        check_quiet("ifu_rd_c4");

        // LSU store, then an LSU load.
        lsu_todo.push_back('{32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
        cycle();
        check("st_rdy", 32'(lsu_req_ready_o), 32'd1);
        cycle();
        check("st_addr", mem_addr_o, 32'h8000_1000);
        check("st_wen", 32'(mem_wen_o), 32'd1);
        check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("st_wmask", 32'(mem_wmask_o), 32'hF);
        run_idle("st", 20);
        lsu_todo.push_back('{32'h8000_2ABC, 1'b0, 32'h0, 4'h0});
        run_idle("ld", 20);

        // Continuous conflict between both requesters.
`ifdef YSYX_25040101_ARB_RR_EN
        exp_order = '{OWN_IFU, OWN_LSU, OWN_IFU, OWN_LSU, OWN_IFU, OWN_LSU};
`else
        exp_order = '{OWN_LSU, OWN_LSU, OWN_LSU, OWN_IFU, OWN_IFU, OWN_IFU};
`endif
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            ifu_todo.push_back('{32'h8000_0100 + 32'(4 * i), 1'b0, 32'h0, 4'h0});
            lsu_todo.push_back('{32'h8000_3000 + 32'(4 * i), 1'(i % 2), 32'h1111_0000 + 32'(i), 4'h5});
        end
        run_idle("conflict", 100);
        check("conflict_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("conflict_order", 32'(grant_log[i]), 32'(exp_order[i]));
        end

        // Memory stall: request held for four cycles while IFU waits.
        stall_cnt = 4;
        lsu_todo.push_back('{32'h8000_4000, 1'b1, 32'hAABB_CCDD, 4'h3});
        cycle();
        check("stall_acc", 32'(lsu_req_ready_o), 32'd1);
        ifu_todo.push_back('{32'h8000_0080, 1'b0, 32'h0, 4'h0});
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_mvld", 32'(mem_req_valid_o), 32'd1);
            check("stall_addr", mem_addr_o, 32'h8000_4000);
            check("stall_wdata", mem_wdata_o, 32'hAABB_CCDD);
            check("stall_ifu_rdy", 32'(ifu_req_ready_o), 32'd0);
        end
        run_idle("stall", 30);

        // Reset while in RSP; the late memory response must be dropped.
        rsp_lat = 3;
        lsu_todo.push_back('{32'h8000_5000, 1'b0, 32'h0, 4'h0});
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        exp_rsp.delete();
        exp_req.delete();
        cycle();
        check_quiet("rst_rsp");
        rst = 1'b0;
        cycle();
        cycle();
        check("rst_drop_mrsp", 32'(mem_rsp_valid_i), 32'd1);
        check("rst_drop_ifu", 32'(ifu_rsp_valid_o), 32'd0);
        check("rst_drop_lsu", 32'(lsu_rsp_valid_o), 32'd0);
        rsp_lat = 1;
        ifu_todo.push_back('{32'h8000_0200, 1'b0, 32'h0, 4'h0});
        run_idle("post_rst", 20);

        check("sb_rsp_left", 32'(exp_rsp.size()), 32'd0);
        check("sb_req_left", 32'(exp_req.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
